// File: rtl/phy_rx_deser_lanes_if.sv
// phy_rx_deser_lanes_if: serial lane inputs and deserialised byte outputs of the receive front end
interface phy_rx_deser_lanes_if #(
    parameter int LANES = 2,
    parameter int WIDTH = 8
);
    logic [LANES-1:0]       data_in;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic [LANES-1:0]       byte_strobe;
    logic [LANES-1:0]       active;
    logic                   all_active;

    modport master (
        output data_in,
        input  data_out, valid_out, byte_strobe, active, all_active
    );

    modport slave (
        input  data_in,
        output data_out, valid_out, byte_strobe, active, all_active
    );
endinterface

// File: rtl/phy_rx_deser_lanes.sv
// phy_rx_deser_lanes: per-lane COM search, byte alignment and activation ahead of unstriping
module phy_rx_deser_lanes #(
    parameter int               LANES        = 2,
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] COM          = 8'hBC,
    parameter logic [WIDTH-1:0] IDL          = 8'h7C,
    parameter int               ACTIVE_COUNT = 4
) (
    input logic                  clk_8f,
    input logic                  reset,
    phy_rx_deser_lanes_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(ACTIVE_COUNT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] COM_LAST = CW'(ACTIVE_COUNT);

    typedef enum logic [1:0] {SEARCH, ALIGNED, ACTIVE} state_e;

    logic [LANES-1:0] act;
    logic             all_active_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_e           state_q, state_d;
        logic [WIDTH-2:0] sr_q;
        logic [WIDTH-1:0] w, data_q, data_d;
        logic [BW-1:0]    bit_q, bit_d;
        logic [CW-1:0]    com_q, com_d;
        logic             valid_q, valid_d, strobe_q, strobe_d;
        logic             bnd, is_com, is_fill;

        assign w       = {sr_q, bus.data_in[i]};
        assign bnd     = bit_q == BIT_LAST;
        assign is_com  = w == COM;
        assign is_fill = is_com || w == IDL;

        always_ff @(posedge clk_8f) begin
            if (reset) begin
                state_q  <= SEARCH;
                sr_q     <= '0;
                bit_q    <= '0;
                com_q    <= '0;
                data_q   <= '0;
                valid_q  <= 1'b0;
                strobe_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                sr_q     <= w[WIDTH-2:0];
                bit_q    <= bit_d;
                com_q    <= com_d;
                data_q   <= data_d;
                valid_q  <= valid_d;
                strobe_q <= strobe_d;
            end
        end

        // In SEARCH bit_q saturates as a fill count so only windows of fully post-reset bits can match COM
        always_comb begin
            state_d  = state_q;
            bit_d    = bnd ? '0 : bit_q + 1'b1;
            com_d    = com_q;
            data_d   = data_q;
            valid_d  = state_q == ACTIVE && valid_q;
            strobe_d = 1'b0;
            case (state_q)
                SEARCH: begin
                    bit_d = bnd ? bit_q : bit_q + 1'b1;
                    if (bnd && is_com) begin
                        state_d = ACTIVE_COUNT == 1 ? ACTIVE : ALIGNED;
                        com_d   = CW'(1);
                        bit_d   = '0;
                    end
                end
                ALIGNED: begin
                    if (bnd && is_com) begin
                        com_d   = com_q + 1'b1;
                        state_d = com_d == COM_LAST ? ACTIVE : ALIGNED;
                    end else if (bnd) begin
                        state_d = SEARCH;
                        com_d   = '0;
                        bit_d   = BIT_LAST;
                    end
                end
                ACTIVE: begin
                    if (bnd) begin
                        strobe_d = 1'b1;
                        valid_d  = !is_fill;
                        data_d   = is_fill ? data_q : w;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        assign bus.data_out[i*WIDTH +: WIDTH] = data_q;
        assign bus.valid_out[i]               = valid_q;
        assign bus.byte_strobe[i]             = strobe_q;
        assign act[i]                         = state_q == ACTIVE;
    end

    always_ff @(posedge clk_8f) begin
        if (reset) all_active_q <= 1'b0;
        else       all_active_q <= &act;
    end

    assign bus.active     = act;
    assign bus.all_active = all_active_q;
endmodule

// File: tb/tb_phy_rx_deser_lanes.sv
// tb_phy_rx_deser_lanes: directed-vector bench for the default 2x8 build and a 4x10 build
module tb_phy_rx_deser_lanes;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [3:0] pat [0:127];

    always #5 clk = ~clk;

    phy_rx_deser_lanes_if #(.LANES(2), .WIDTH(8)) ifa ();
    phy_rx_deser_lanes_if #(.LANES(4), .WIDTH(10)) ifb ();

    phy_rx_deser_lanes dut_a (.clk_8f(clk), .reset(reset), .bus(ifa.slave));

    phy_rx_deser_lanes #(
        .LANES(4), .WIDTH(10), .COM(10'h17C), .IDL(10'h0F0), .ACTIVE_COUNT(2)
    ) dut_b (.clk_8f(clk), .reset(reset), .bus(ifb.slave));

    task automatic clear_pat();
        for (int k = 0; k < 128; k++) pat[k] = '0;
    endtask

    task automatic put(input int lane, input int start, input int w, input logic [9:0] val);
        for (int b = 0; b < w; b++) pat[start+b][lane] = val[w-1-b];
    endtask

    // Edge n (1-based after reset release) samples pat[n-1]; outputs are observed 1 time unit later
    task automatic tick(input int n);
        ifa.data_in = pat[n-1][1:0];
        ifb.data_in = pat[n-1];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifa.data_in = '1;
        ifb.data_in = '1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ifa.data_out, ifa.valid_out, ifa.byte_strobe, ifa.active, ifa.all_active} !== '0) begin
            errors++;
            $display("FAIL reset_a: got %h %b %b %b %b required all zero", ifa.data_out, ifa.valid_out, ifa.byte_strobe, ifa.active, ifa.all_active);
        end
        checks++;
        if ({ifb.data_out, ifb.valid_out, ifb.byte_strobe, ifb.active, ifb.all_active} !== '0) begin
            errors++;
            $display("FAIL reset_b: got %h %b %b %b %b required all zero", ifb.data_out, ifb.valid_out, ifb.byte_strobe, ifb.active, ifb.all_active);
        end
        clear_pat();
        for (int n = 1; n <= 50; n++) begin
            tick(n);
            checks++;
            if ({ifa.data_out, ifa.valid_out, ifa.byte_strobe, ifa.active, ifa.all_active} !== '0) begin
                errors++;
                $display("FAIL idle_zero cycle %0d: got %h %b %b %b %b required all zero", n, ifa.data_out, ifa.valid_out, ifa.byte_strobe, ifa.active, ifa.all_active);
            end
        end
    endtask

    task automatic test_lane0_lock();
        clear_pat();
        for (int k = 0; k < 4; k++) put(0, k*8, 8, 10'h0BC);
        put(0, 32, 8, 10'h055);
        put(0, 40, 8, 10'h0A3);
        do_reset();
        for (int n = 1; n <= 48; n++) begin
            tick(n);
            checks++;
            if (ifa.active !== {1'b0, n >= 32} || ifa.all_active !== 1'b0) begin
                errors++;
                $display("FAIL lock_active cycle %0d: got %b/%b required %b/0", n, ifa.active, ifa.all_active, {1'b0, n >= 32});
            end
            checks++;
            if (ifa.valid_out !== {1'b0, n >= 40} || ifa.byte_strobe !== {1'b0, n == 40 || n == 48}) begin
                errors++;
                $display("FAIL lock_valid_strobe cycle %0d: got %b/%b required %b/%b", n, ifa.valid_out, ifa.byte_strobe, {1'b0, n >= 40}, {1'b0, n == 40 || n == 48});
            end
            if (n == 40 || n == 48) begin
                checks++;
                if (ifa.data_out[7:0] !== (n == 40 ? 8'h55 : 8'hA3)) begin
                    errors++;
                    $display("FAIL lock_data cycle %0d: got %h required %h", n, ifa.data_out[7:0], n == 40 ? 8'h55 : 8'hA3);
                end
            end
        end
    endtask

    task automatic test_two_lanes();
        clear_pat();
        for (int k = 0; k < 4; k++) put(0, k*8, 8, 10'h0BC);
        put(0, 32, 8, 10'h055);
        put(0, 40, 8, 10'h0A3);
        put(1, 0, 3, 10'h005);
        for (int k = 0; k < 4; k++) put(1, 3 + k*8, 8, 10'h0BC);
        put(1, 35, 8, 10'h011);
        put(1, 43, 8, 10'h07C);
        put(1, 51, 8, 10'h022);
        do_reset();
        for (int n = 1; n <= 60; n++) begin
            tick(n);
            checks++;
            if (ifa.active !== {n >= 35, n >= 32} || ifa.all_active !== (n >= 36)) begin
                errors++;
                $display("FAIL two_active cycle %0d: got %b/%b required %b/%b", n, ifa.active, ifa.all_active, {n >= 35, n >= 32}, n >= 36);
            end
            checks++;
            if (ifa.byte_strobe[1] !== (n == 43 || n == 51 || n == 59)) begin
                errors++;
                $display("FAIL lane1_strobe cycle %0d: got %b required %b", n, ifa.byte_strobe[1], n == 43 || n == 51 || n == 59);
            end
            if (n == 43 || n == 51 || n == 59) begin
                checks++;
                if (ifa.valid_out[1] !== (n != 51) || ifa.data_out[15:8] !== (n == 59 ? 8'h22 : 8'h11)) begin
                    errors++;
                    $display("FAIL lane1_byte cycle %0d: got valid %b data %h required valid %b data %h", n, ifa.valid_out[1], ifa.data_out[15:8], n != 51, n == 59 ? 8'h22 : 8'h11);
                end
            end
        end
    endtask

    task automatic test_relock();
        clear_pat();
        put(0, 0, 8, 10'h0BC);
        put(0, 8, 8, 10'h0BC);
        put(0, 16, 8, 10'h000);
        for (int k = 0; k < 4; k++) put(0, 24 + k*8, 8, 10'h0BC);
        put(0, 56, 8, 10'h03C);
        do_reset();
        for (int n = 1; n <= 64; n++) begin
            tick(n);
            checks++;
            if (ifa.active[0] !== (n >= 56) || ifa.valid_out[0] !== (n >= 64)) begin
                errors++;
                $display("FAIL relock_state cycle %0d: got active %b valid %b required %b %b", n, ifa.active[0], ifa.valid_out[0], n >= 56, n >= 64);
            end
        end
        checks++;
        if (ifa.data_out[7:0] !== 8'h3C || ifa.byte_strobe[0] !== 1'b1) begin
            errors++;
            $display("FAIL relock_data: got %h strobe %b required 3c strobe 1", ifa.data_out[7:0], ifa.byte_strobe[0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_pat();
        for (int k = 0; k < 4; k++) put(0, k*8, 8, 10'h0BC);
        put(0, 32, 8, 10'h055);
        put(0, 40, 3, 10'h007);
        do_reset();
        for (int n = 1; n <= 43; n++) tick(n);
        checks++;
        if (ifa.active[0] !== 1'b1 || ifa.data_out[7:0] !== 8'h55) begin
            errors++;
            $display("FAIL mid_pre: got active %b data %h required 1 55", ifa.active[0], ifa.data_out[7:0]);
        end
        do_reset();
        checks++;
        if ({ifa.data_out[7:0], ifa.valid_out[0], ifa.byte_strobe[0], ifa.active[0]} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got data %h valid %b strobe %b active %b required all zero", ifa.data_out[7:0], ifa.valid_out[0], ifa.byte_strobe[0], ifa.active[0]);
        end
        clear_pat();
        for (int k = 0; k < 4; k++) put(0, 4 + k*8, 8, 10'h0BC);
        put(0, 36, 8, 10'h09A);
        for (int n = 1; n <= 44; n++) begin
            tick(n);
            checks++;
            if (ifa.active[0] !== (n >= 36) || ifa.valid_out[0] !== (n >= 44) || ifa.data_out[7:0] !== (n >= 44 ? 8'h9A : 8'h00)) begin
                errors++;
                $display("FAIL mid_recover cycle %0d: got active %b valid %b data %h required %b %b %h", n, ifa.active[0], ifa.valid_out[0], ifa.data_out[7:0], n >= 36, n >= 44, n >= 44 ? 8'h9A : 8'h00);
            end
        end
    endtask

    task automatic test_wide();
        logic [9:0] d [0:3];
        d[0] = 10'h123; d[1] = 10'h2C5; d[2] = 10'h3A7; d[3] = 10'h05B;
        clear_pat();
        for (int l = 0; l < 4; l++) begin
            put(l, l, 10, 10'h17C);
            put(l, l + 10, 10, 10'h17C);
            put(l, l + 20, 10, d[l]);
        end
        do_reset();
        for (int n = 1; n <= 35; n++) begin
            tick(n);
            checks++;
            if (ifb.active !== {n >= 23, n >= 22, n >= 21, n >= 20} || ifb.all_active !== (n >= 24)) begin
                errors++;
                $display("FAIL wide_active cycle %0d: got %b/%b required %b/%b", n, ifb.active, ifb.all_active, {n >= 23, n >= 22, n >= 21, n >= 20}, n >= 24);
            end
            for (int l = 0; l < 4; l++) begin
                if (n == l + 30) begin
                    checks++;
                    if (ifb.data_out[l*10 +: 10] !== d[l] || ifb.valid_out[l] !== 1'b1 || ifb.byte_strobe[l] !== 1'b1) begin
                        errors++;
                        $display("FAIL wide_byte lane %0d: got %h valid %b strobe %b required %h 1 1", l, ifb.data_out[l*10 +: 10], ifb.valid_out[l], ifb.byte_strobe[l], d[l]);
                    end
                end
            end
        end
        checks++;
        if (ifb.data_out !== {d[3], d[2], d[1], d[0]} || ifb.valid_out !== 4'hF) begin
            errors++;
            $display("FAIL wide_bus: got %h valid %b required %h 1111", ifb.data_out, ifb.valid_out, {d[3], d[2], d[1], d[0]});
        end
    endtask

    initial begin
        ifa.data_in = '0;
        ifb.data_in = '0;
        clear_pat();
        @(posedge clk);
        #1;
        test_reset();
        test_lane0_lock();
        test_two_lanes();
        test_relock();
        test_reset_mid();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
